// File: rtl/uart_reg_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_reg_bridge_if
//  Purpose  : Byte-stream handshake between uart_rx/uart_tx and the
//             register bridge.
//  Signals  : rx_data  [7:0] received byte         (uart -> bridge)
//             rx_ready       byte available, level (uart -> bridge)
//             rx_read        consume pulse         (bridge -> uart)
//             tx_data  [7:0] byte to transmit      (bridge -> uart)
//             tx_ready       transmitter idle      (uart -> bridge)
//             tx_write       launch pulse          (bridge -> uart)
//  Modports : master = bridge side, slave = uart side
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_reg_bridge_if;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_read;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_write;

   modport master (
      input  rx_data, rx_ready, tx_ready,
      output rx_read, tx_data, tx_write
   );

   modport slave (
      output rx_data, rx_ready, tx_ready,
      input  rx_read, tx_data, tx_write
   );
endinterface
`default_nettype wire

// File: rtl/uart_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : uart_reg_bridge
//  Purpose  : Command-parser FSM turning the UART byte stream into accesses
//             on a bank of NREGS 8-bit registers.
//               'm' addr <= acc        'w' slot[addr] <= acc
//               'r' send in_regs[addr]  'o' send out_regs[addr]
//               other bytes shift their low nibble into acc
//  Ports    : clk, reset             clock, synchronous active-high reset
//             bus (master)           uart_rx / uart_tx byte handshake
//             out_regs [NREGS*8]     packed output registers
//             in_regs  [NREGS*8]     packed input ports
//             wr_stb   [NREGS]       one-hot pulse on the written slot
//             rd_stb   [NREGS]       one-hot pulse on the slot read by 'r'
//  Options  : UART_REG_BRIDGE_AUTOINC_EN - advance addr (wrapping at NREGS)
//             after every 'w', 'r' and 'o'.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_reg_bridge #(
   parameter int                 NREGS     = 32,
   parameter logic [NREGS*8-1:0] RESET_VAL = {NREGS{8'h00}}
) (
   input  wire                    clk,
   input  wire                    reset,
   uart_reg_bridge_if.master      bus,
   output logic [NREGS*8-1:0]     out_regs,
   input  wire  [NREGS*8-1:0]     in_regs,
   output logic [NREGS-1:0]       wr_stb,
   output logic [NREGS-1:0]       rd_stb
);

   localparam int         c_IDXW  = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [8:0] c_NREGS = 9'(NREGS);

   localparam logic [7:0] c_CMD_M = 8'h6D;
   localparam logic [7:0] c_CMD_W = 8'h77;
   localparam logic [7:0] c_CMD_R = 8'h72;
   localparam logic [7:0] c_CMD_O = 8'h6F;

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_DECODE = 3'd1;
   localparam logic [2:0] c_RXCLR  = 3'd2;
   localparam logic [2:0] c_TXWAIT = 3'd3;
   localparam logic [2:0] c_TXACK  = 3'd4;

   logic [2:0]       r_state;
   logic [7:0]       r_byte;
   logic [7:0]       r_acc;
   logic [7:0]       r_addr;
   logic             r_rd_pend;
   logic [7:0]       r_rd_byte;
   logic             r_rx_read;
   logic             r_tx_write;
   logic [7:0]       r_tx_data;
   logic [NREGS-1:0] r_wr_stb;
   logic [NREGS-1:0] r_rd_stb;
   logic [7:0]       r_slot [NREGS];

   logic [7:0]        w_in_slot [NREGS];
   logic [NREGS-1:0]  w_wr_hit;
   logic [NREGS-1:0]  w_rd_hit;
   logic              w_addr_ok;
   logic [c_IDXW-1:0] w_idx;
   logic              w_is_w;
   logic              w_is_r;
   logic [7:0]        w_rd_val;
   logic [7:0]        w_addr_step;

   assign w_addr_ok = ({1'b0, r_addr} < c_NREGS);
   assign w_idx     = r_addr[c_IDXW-1:0];
   assign w_is_w    = (r_state == c_DECODE) && (r_byte == c_CMD_W);
   assign w_is_r    = (r_state == c_DECODE) && (r_byte == c_CMD_R);

`ifdef UART_REG_BRIDGE_AUTOINC_EN
   localparam logic [7:0] c_LAST = 8'(NREGS - 1);
   // Out-of-range addresses also fall into the wrap branch and restart at 0.
   assign w_addr_step = (r_addr >= c_LAST) ? 8'h00 : r_addr + 8'h01;
`else
   assign w_addr_step = r_addr;
`endif

   // ------------------------------------------------------------------------
   // Register slots. An address can only equal k when k < NREGS, so the
   // strobe decode needs no separate range check.
   // ------------------------------------------------------------------------
   generate
      for (genvar k = 0; k < NREGS; k++) begin : g_slot
         localparam logic [7:0] c_K = 8'(k);

         assign w_in_slot[k]          = in_regs[8*k +: 8];
         assign w_wr_hit[k]           = w_is_w && (r_addr == c_K);
         // rd_stb marks reads of the input ports only ('r'); 'o' readback of
         // our own register has no side effect worth signalling.
         assign w_rd_hit[k]           = w_is_r && (r_addr == c_K);
         assign out_regs[8*k +: 8]    = r_slot[k];

         always_ff @(posedge clk) begin
            if (reset) begin
               r_slot[k] <= RESET_VAL[8*k +: 8];
            end else if (w_wr_hit[k]) begin
               r_slot[k] <= r_acc;
            end
         end
      end
   endgenerate

   // Read source for 'r' / 'o'; out-of-range reads return 0xFF.
   always_comb begin
      w_rd_val = 8'hFF;
      if (w_addr_ok) begin
         if (r_byte == c_CMD_R) begin
            w_rd_val = w_in_slot[w_idx];
         end else begin
            w_rd_val = r_slot[w_idx];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Command parser FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= c_IDLE;
         r_byte     <= 8'h00;
         r_acc      <= 8'h00;
         r_addr     <= 8'h00;
         r_rd_pend  <= 1'b0;
         r_rd_byte  <= 8'h00;
         r_rx_read  <= 1'b0;
         r_tx_write <= 1'b0;
         r_tx_data  <= 8'h00;
         r_wr_stb   <= '0;
         r_rd_stb   <= '0;
      end else begin
         r_rx_read  <= 1'b0;
         r_tx_write <= 1'b0;
         r_wr_stb   <= w_wr_hit;
         r_rd_stb   <= w_rd_hit;

         case (r_state)
            c_IDLE: begin
               if (bus.rx_ready) begin
                  r_byte    <= bus.rx_data;
                  r_rx_read <= 1'b1;
                  r_state   <= c_DECODE;
               end
            end

            c_DECODE: begin
               r_state   <= c_RXCLR;
               r_rd_pend <= 1'b0;
               case (r_byte)
                  c_CMD_M: r_addr <= r_acc;
                  c_CMD_W: r_addr <= w_addr_step;
                  c_CMD_R, c_CMD_O: begin
                     // Captured here so later in_regs changes cannot alter
                     // the byte that is eventually transmitted.
                     r_addr    <= w_addr_step;
                     r_rd_pend <= 1'b1;
                     r_rd_byte <= w_rd_val;
                  end
                  default: r_acc <= {r_acc[3:0], r_byte[3:0]};
               endcase
            end

            c_RXCLR: begin
               if (!bus.rx_ready) begin
                  r_state <= r_rd_pend ? c_TXWAIT : c_IDLE;
               end
            end

            c_TXWAIT: begin
               if (bus.tx_ready) begin
                  r_tx_write <= 1'b1;
                  r_tx_data  <= r_rd_byte;
                  r_state    <= c_TXACK;
               end
            end

            c_TXACK: begin
               if (!bus.tx_ready) begin
                  r_rd_pend <= 1'b0;
                  r_state   <= c_IDLE;
               end
            end

            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign bus.rx_read  = r_rx_read;
   assign bus.tx_write = r_tx_write;
   assign bus.tx_data  = r_tx_data;
   assign wr_stb       = r_wr_stb;
   assign rd_stb       = r_rd_stb;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_reg_bridge
//  Purpose  : Self-checking bench for uart_reg_bridge (NREGS=32, slot 6
//             reset value 0x40). Transmitted bytes are checked against a
//             scoreboard queue filled when the 'r'/'o' command is sent.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_reg_bridge;

   localparam int           c_NREGS = 32;
   localparam logic [255:0] c_RST   = 256'h40 << 48;

   logic               clk;
   logic               reset;
   logic [255:0]       out_regs;
   logic [255:0]       in_regs;
   logic [31:0]        wr_stb;
   logic [31:0]        rd_stb;

   uart_reg_bridge_if bus ();

   uart_reg_bridge #(
      .NREGS     (c_NREGS),
      .RESET_VAL (c_RST)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .out_regs (out_regs),
      .in_regs  (in_regs),
      .wr_stb   (wr_stb),
      .rd_stb   (rd_stb)
   );

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [7:0]   exp_q [$];
   logic [255:0] exp_out;
   logic [31:0]  s_wr;
   logic [31:0]  s_rd;
   int           lat;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Send one byte as uart_rx would; s_wr/s_rd hold the strobes two cycles
   // after rx_ready rose (cycle 2) and lat the cycle in which rx_read came.
   task automatic send_byte(input logic [7:0] b, output int l);
      bit          got = 0;
      logic [63:0] pre;
      l = -1;
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.rx_read === 1'b1) begin
            got = 1;
            l   = i + 1;
            break;
         end
      end
      pre = {wr_stb, rd_stb};
      bus.rx_ready = 1'b0;
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL rx_read_timeout: byte %h got no rx_read within 40 cycles", b);
      end
      @(posedge clk); #1;
      s_wr = wr_stb;
      s_rd = rd_stb;
      @(posedge clk); #1;
      n_tests++;
      if (pre !== 64'h0 || wr_stb !== 32'h0 || rd_stb !== 32'h0) begin
         n_fail++;
         $display("FAIL strobe_width: byte %h pre=%h post wr=%h rd=%h, want all 0",
                  b, pre, wr_stb, rd_stb);
      end
   endtask

   task automatic send_str(input string s);
      int l;
      for (int i = 0; i < s.len(); i++) send_byte(s[i], l);
   endtask

   // Act as uart_tx: hold tx_ready low for 'hold' cycles, then accept one
   // byte, compare with the scoreboard, and confirm no extra tx_write.
   task automatic wait_tx(input int hold);
      int         cnt = 0;
      bit         got = 0;
      logic [7:0] exp;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (bus.tx_write === 1'b1) cnt++;
      end
      if (hold > 0) begin
         n_tests++;
         if (cnt != 0) begin
            n_fail++;
            $display("FAIL tx_early: %0d tx_write while tx_ready=0, want 0", cnt);
         end
      end
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.tx_write === 1'b1) begin
            got = 1;
            break;
         end
      end
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL tx_scoreboard: tx_data %h with no expected byte queued", bus.tx_data);
      end else begin
         exp = exp_q.pop_front();
         if (!got) begin
            n_fail++;
            $display("FAIL tx_timeout: no tx_write, want byte %h", exp);
         end else if (bus.tx_data !== exp) begin
            n_fail++;
            $display("FAIL tx_data: got %h, want %h", bus.tx_data, exp);
         end
      end
      cnt = 0;
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus.tx_write === 1'b1) cnt++;
      end
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (bus.tx_write === 1'b1) cnt++;
      end
      n_tests++;
      if (cnt != 0) begin
         n_fail++;
         $display("FAIL tx_extra: %0d extra tx_write pulses, want 0", cnt);
      end
   endtask

   task automatic check_out(input string name);
      n_tests++;
      if (out_regs !== exp_out) begin
         n_fail++;
         $display("FAIL %s: out_regs=%h want %h", name, out_regs, exp_out);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_tests++;
      if (out_regs !== c_RST) begin
         n_fail++;
         $display("FAIL %s_out_regs: got %h, want %h", name, out_regs, c_RST);
      end
      n_tests++;
      if (bus.tx_write !== 1'b0 || bus.rx_read !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_pulses: tx_write=%b rx_read=%b, want 0 0", name,
                  bus.tx_write, bus.rx_read);
      end
      n_tests++;
      if (bus.tx_data !== 8'h00 || wr_stb !== 32'h0 || rd_stb !== 32'h0) begin
         n_fail++;
         $display("FAIL %s_misc: tx_data=%h wr_stb=%h rd_stb=%h, want 0", name,
                  bus.tx_data, wr_stb, rd_stb);
      end
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      bus.rx_ready = 1'b0;
      bus.rx_data  = 8'h00;
      bus.tx_ready = 1'b1;
      in_regs      = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      exp_out = c_RST;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_write();
      send_byte("1", lat);
      n_tests++;
      if (lat != 1) begin
         n_fail++;
         $display("FAIL rx_latency: rx_read in cycle %0d, want 1", lat);
      end
      send_str("2m5:");
      n_tests++;
      if (s_wr !== 32'h0) begin
         n_fail++;
         $display("FAIL wr_stb_nonwrite: got %h, want 0", s_wr);
      end
      send_byte("w", lat);
      exp_out[18*8 +: 8] = 8'h5A;
      n_tests++;
      if (s_wr !== (32'h1 << 18)) begin
         n_fail++;
         $display("FAIL wr_stb_slot18: got %h, want %h", s_wr, 32'h1 << 18);
      end
      check_out("write_slot18");
      send_byte("w", lat);
      n_tests++;
      if (s_wr !== (32'h1 << 18)) begin
         n_fail++;
         $display("FAIL wr_repeat: got %h, want %h", s_wr, 32'h1 << 18);
      end
      check_out("write_repeat");
      exp_q.push_back(8'h5A);
      send_byte("o", lat);
      wait_tx(0);
   endtask

   task automatic test_read();
      in_regs[5*8 +: 8] = 8'hC3;
      send_str("05m");
      bus.tx_ready = 1'b0;
      exp_q.push_back(8'hC3);
      send_byte("r", lat);
      n_tests++;
      if (s_rd !== (32'h1 << 5)) begin
         n_fail++;
         $display("FAIL rd_stb_slot5: got %h, want %h", s_rd, 32'h1 << 5);
      end
      in_regs[5*8 +: 8] = 8'h11;
      wait_tx(6);
   endtask

   task automatic test_out_of_range();
      send_str("??m");
      exp_q.push_back(8'hFF);
      send_byte("r", lat);
      n_tests++;
      if (s_rd !== 32'h0) begin
         n_fail++;
         $display("FAIL rd_stb_oor: got %h, want 0", s_rd);
      end
      wait_tx(0);
      send_byte("w", lat);
      n_tests++;
      if (s_wr !== 32'h0) begin
         n_fail++;
         $display("FAIL wr_stb_oor: got %h, want 0", s_wr);
      end
      check_out("write_oor");
      exp_q.push_back(8'hFF);
      send_byte("o", lat);
      wait_tx(0);
   endtask

   task automatic test_reset_mid();
      int cnt = 0;
      in_regs[3*8 +: 8] = 8'h77;
      send_str("03m");
      bus.tx_ready = 1'b0;
      send_byte("r", lat);
      @(negedge clk);
      bus.rx_data  = "7";
      bus.rx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.rx_read === 1'b1 || bus.tx_write === 1'b1) cnt++;
      end
      n_tests++;
      if (cnt != 0) begin
         n_fail++;
         $display("FAIL rx_buffered: %0d rx_read/tx_write during TXWAIT, want 0", cnt);
      end
      @(negedge clk);
      reset        = 1'b1;
      bus.rx_ready = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("reset_mid");
      @(negedge clk);
      reset        = 1'b0;
      bus.tx_ready = 1'b1;
      exp_out      = c_RST;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.tx_write === 1'b1) cnt++;
      end
      n_tests++;
      if (cnt != 0) begin
         n_fail++;
         $display("FAIL tx_dropped: %0d tx_write after reset, want 0", cnt);
      end
      in_regs[7:0] = 8'h9E;
      exp_q.push_back(8'h9E);
      send_byte("r", lat);
      n_tests++;
      if (s_rd !== 32'h1) begin
         n_fail++;
         $display("FAIL rd_after_reset: rd_stb=%h, want 00000001", s_rd);
      end
      wait_tx(0);
   endtask

   task automatic test_addr_step();
      send_str("1?m69");
      send_byte("w", lat);
      exp_out[31*8 +: 8] = 8'h69;
      n_tests++;
      if (s_wr !== (32'h1 << 31)) begin
         n_fail++;
         $display("FAIL wr_slot31: got %h, want %h", s_wr, 32'h1 << 31);
      end
      check_out("write_slot31");
`ifdef UART_REG_BRIDGE_AUTOINC_EN
      exp_q.push_back(exp_out[7:0]);
      send_byte("o", lat);
      wait_tx(0);
      send_byte("w", lat);
      n_tests++;
      if (s_wr !== 32'h2) begin
         n_fail++;
         $display("FAIL autoinc_addr1: wr_stb=%h, want 00000002", s_wr);
      end
`else
      exp_q.push_back(8'h69);
      send_byte("o", lat);
      wait_tx(0);
      send_byte("w", lat);
      n_tests++;
      if (s_wr !== (32'h1 << 31)) begin
         n_fail++;
         $display("FAIL addr_hold: wr_stb=%h, want %h", s_wr, 32'h1 << 31);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_out_of_range();
      test_reset_mid();
      test_addr_step();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_left: %0d bytes never transmitted, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
